fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port between NUM_REQ producers.
- Each producer offers a word with req/gnt; the arbiter picks at most one per cycle and drives a registered wr_en/data_in into the FIFO.
- Write issue is gated on FIFO full/almostfull so that no write is ever issued into a full FIFO.
- Monitors the FIFO's wr_ack/overflow handshake and raises sticky error flags.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 16, FIFO word width.
- CNT_WIDTH, 16, width of per-producer grant counters (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-producer write request; must hold with stable data until granted.
- req_data  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot or zero, combinational; producer i's word is accepted in the cycle req[i]&gnt[i].
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO count == depth-1.
- fifo_wr_ack  in  1  FIFO write acknowledge, one cycle after an accepted write.
- fifo_overflow  in  1  FIFO overflow flag.
- fifo_wr_en  out  1  registered write enable to the FIFO.
- fifo_data_in  out  DATA_WIDTH  registered write data.
- err_overflow  out  1  sticky; set when fifo_overflow is seen high.
- err_ack  out  1  sticky; set when fifo_wr_ack is low in the cycle after fifo_wr_en was high.
- busy  out  1  high when any req is high or fifo_wr_en is high.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - fifo_wr_en=0, fifo_data_in=0, err_overflow=0, err_ack=0.
  - Round-robin pointer rr_ptr=0; ack-pending flag cleared.
  - gnt is forced to 0 while rst=1.
  - A reset asserted mid-stream drops any registered, not-yet-issued write. The producer is not re-granted for that word.
- Issue gate: can_issue = !fifo_full && !(fifo_wr_en && fifo_almostfull).
  - The second term covers the in-flight write already registered into a FIFO at depth-1.
- Arbitration when can_issue=1:
  - Scan from rr_ptr upward, modulo NUM_REQ.
  - The first i with req[i]=1 gets gnt[i]=1.
- When can_issue=0, or no req is high, gnt=0.
- Latency:
  - A grant in cycle t gives fifo_wr_en=1 and fifo_data_in=req_data[i] in cycle t+1.
  - fifo_wr_ack is expected in cycle t+2.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - Wrap-around: a grant to NUM_REQ-1 sets rr_ptr=0.
- fifo_wr_en is high for exactly one cycle per grant.
  - Back-to-back grants give fifo_wr_en high in consecutive cycles (full throughput).
- Ack check:
  - An ack-pending flag is registered from fifo_wr_en.
  - If the flag is 1, fifo_wr_ack=0 and fifo_overflow=0 in the same cycle, err_ack sets.
- Sticky errors: err_overflow and err_ack are cleared only by rst.
- Simultaneous events:
  - fifo_full=1 with all req high: no grant, and rr_ptr is unchanged. Fairness is preserved across stalls.
  - A req dropped before being granted is legal and causes no grant.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined:
  - Adds output port grant_cnt, width NUM_REQ*CNT_WIDTH.
  - Provides one counter per producer, incremented on each gnt[i] and saturating at all-ones.
  - Counters reset to 0 on rst.
- When undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with req=4'b1111 -> gnt=0, fifo_wr_en=0, both err flags 0, first grant after release is gnt=4'b0001.
- Round-robin: hold req=4'b1111 for 8 cycles, FIFO never full -> gnt sequence 0001,0010,0100,1000,0001,...; fifo_data_in follows the granted data one cycle later.
- Skip and wrap: req=4'b1001 with rr_ptr=1 -> gnt=1000, then gnt=0001 (rr_ptr wraps to 0 then 1).
- Full boundary, depth 8: fill to count 7 with a write in flight (fifo_almostfull=1, fifo_wr_en=1) and req=4'b0010 -> gnt=0 that cycle. After a FIFO read frees space (full=0, almostfull=0), gnt=0010 and fifo_overflow stays 0.
- Error flags: force fifo_wr_ack=0 the cycle after a write -> err_ack=1 and remains 1 until rst. Pulse fifo_overflow=1 -> err_overflow=1 sticky.
- Stats (FIFO_ARB_STATS_EN, CNT_WIDTH=2): grant producer 0 five times -> grant_cnt[1:0] saturates at 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one synchronous FIFO write
// port between NUM_REQ producers. The grant is combinational, the FIFO write is
// registered. Writes are held off when the FIFO is full, or when it is one slot
// short of full with a write already in flight. The wr_ack/overflow handshake
// drives two sticky error flags.
// Optional build macro FIFO_ARB_STATS_EN adds saturating per-producer grant
// counters on output port grant_cnt.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          err_overflow,
    output logic                          err_ack,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject parameter sets the arbiter is not meant to handle.
    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
        $error("fifo_wr_arbiter: unsupported parameter set");
    end

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             can_issue;
    logic             ack_pend_p1;

    // A write already registered into a FIFO at depth-1 fills it, so block
    // the next grant in that case as well as when the FIFO is full.
    assign can_issue = !fifo_full && !(fifo_wr_en && fifo_almostfull);

    assign busy = (|req) || fifo_wr_en;

    // Grant selection: search upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (!rst && can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!gnt_any && req[idx]) begin
                    gnt_any      = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = PTR_W'(idx);
                end
            end
        end
    end

    // ---- stage p1: registered write issue and round-robin pointer ----
    // Register the granted word and move the pointer just past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            rr_ptr       <= '0;
        end else begin
            fifo_wr_en <= gnt_any;
            if (gnt_any) begin
                fifo_data_in <= req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr       <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // ---- stage p2: ack window follows the write by one cycle ----
    // Track the expected ack and latch the sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_pend_p1  <= 1'b0;
            err_ack      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            ack_pend_p1 <= fifo_wr_en;
            if (ack_pend_p1 && !fifo_wr_ack && !fifo_overflow) begin
                err_ack <= 1'b1;
            end
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Count grants per producer, holding at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    assign grant_cnt = cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus a randomized run,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req;
    logic [DW-1:0]   pd [N];
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic            err_overflow, err_ack, busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    assign req_data = {pd[3], pd[2], pd[1], pd[0]};

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .err_overflow(err_overflow), .err_ack(err_ack), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    // reference model state
    int            m_ptr;
    bit            m_wr_en, m_pend, m_eack, m_eovf;
    logic [DW-1:0] m_data;
    int            m_cnt [N];
    logic [N-1:0]  exp_gnt;
    int            exp_idx, last_idx;
    bit            auto_ack;
    int            checks, errors;

    // Compute the expected grant for the inputs now applied.
    task automatic settle();
        #1;
        exp_gnt = '0;
        exp_idx = -1;
        if (!rst && !fifo_full && !(m_wr_en && fifo_almostfull)) begin
            for (int k = 0; k < N; k++) begin
                if (exp_idx < 0 && req[(m_ptr + k) % N]) exp_idx = (m_ptr + k) % N;
            end
        end
        if (exp_idx >= 0) exp_gnt[exp_idx] = 1'b1;
    endtask

    // Advance the model across one clock edge, then the DUT.
    task automatic clk_edge();
        last_idx = exp_idx;
        if (rst) begin
            m_wr_en = 0; m_data = '0; m_ptr = 0; m_pend = 0; m_eack = 0; m_eovf = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (m_pend && !fifo_wr_ack && !fifo_overflow) m_eack = 1;
            if (fifo_overflow) m_eovf = 1;
            m_pend = m_wr_en;
            if (exp_idx >= 0) begin
                m_wr_en = 1;
                m_data  = pd[exp_idx];
                m_ptr   = (exp_idx + 1) % N;
                if (m_cnt[exp_idx] < (1 << CW) - 1) m_cnt[exp_idx]++;
            end else begin
                m_wr_en = 0;
            end
        end
        @(posedge clk);
        #1;
        fifo_wr_ack = auto_ack && m_pend;
    endtask

    task automatic test_reset();
        rst = 1; req = '1;
        for (int i = 0; i < N; i++) pd[i] = DW'($urandom);
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
            clk_edge();
            checks++;
            if (fifo_wr_en !== 1'b0 || fifo_data_in !== '0 || err_ack !== 1'b0 || err_overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: wr_en=%b data=%h err_ack=%b err_ovf=%b want all 0",
                         fifo_wr_en, fifo_data_in, err_ack, err_overflow);
            end
        end
        rst = 0;
        settle();
        checks++;
        if (gnt !== 4'b0001 || gnt !== exp_gnt) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
        clk_edge();
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_data_in !== pd[0] || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_wr: wr_en=%b data=%h busy=%b want 1 %h 1", fifo_wr_en, fifo_data_in, busy, pd[0]);
        end
        req = '0; settle(); clk_edge();
    endtask

    task automatic test_mid_reset();
        req = 4'b0100;
        settle(); clk_edge();
        rst = 1; req = '0;
        settle();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
        clk_edge();
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_data_in !== '0) begin
            errors++; $display("FAIL midrst_drop: wr_en=%b data=%h want 0 0000", fifo_wr_en, fifo_data_in);
        end
        rst = 0;
        settle();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL midrst_regrant: got %b want 0000", gnt); end
        clk_edge();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        req = '1;
        for (int k = 0; k < 8; k++) begin
            settle();
            want = N'(1) << (k % N);
            checks++;
            if (gnt !== want || gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, want); end
            clk_edge();
            checks++;
            if (fifo_wr_en !== 1'b1 || fifo_data_in !== m_data) begin
                errors++; $display("FAIL rr_data[%0d]: wr_en=%b data=%h want 1 %h", k, fifo_wr_en, fifo_data_in, m_data);
            end
            pd[last_idx] = DW'($urandom);
        end
        req = '0; settle(); clk_edge();
    endtask

    task automatic test_skip_wrap();
        req = 4'b0001; settle(); clk_edge();
        req = 4'b1001;
        settle();
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_skip: got %b want 1000", gnt); end
        clk_edge();
        settle();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_zero: got %b want 0001", gnt); end
        clk_edge();
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_data_in !== pd[0]) begin
            errors++; $display("FAIL wrap_data: wr_en=%b data=%h want 1 %h", fifo_wr_en, fifo_data_in, pd[0]);
        end
        req = '0; settle(); clk_edge();
    endtask

    task automatic test_full_boundary();
        req = 4'b0001; settle(); clk_edge();
        fifo_almostfull = 1; req = 4'b0010;
        settle();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL af_inflight: got %b want 0000", gnt); end
        clk_edge();
        fifo_full = 1; fifo_almostfull = 0;
        settle();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL full_block: got %b want 0000", gnt); end
        clk_edge();
        fifo_full = 0;
        settle();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL full_release: got %b want 0010", gnt); end
        clk_edge();
        checks++;
        if (fifo_wr_en !== 1'b1 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL full_release_wr: wr_en=%b err_ovf=%b want 1 0", fifo_wr_en, err_overflow);
        end
        // stall with everyone requesting: pointer must not move
        req = '1; fifo_full = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (gnt !== '0) begin errors++; $display("FAIL stall_gnt[%0d]: got %b want 0000", c, gnt); end
            clk_edge();
        end
        fifo_full = 0;
        settle();
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_fair: got %b want 0100", gnt); end
        clk_edge();
        req = '0; settle(); clk_edge();
    endtask

    task automatic test_errors();
        auto_ack = 0;
        req = 4'b0001; settle(); clk_edge();
        req = '0; settle(); clk_edge();
        settle(); clk_edge();
        auto_ack = 1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (err_ack !== 1'b1 || err_ack !== m_eack) begin errors++; $display("FAIL err_ack[%0d]: got %b want 1", c, err_ack); end
            settle(); clk_edge();
        end
        fifo_overflow = 1; settle(); clk_edge();
        fifo_overflow = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (err_overflow !== 1'b1) begin errors++; $display("FAIL err_ovf[%0d]: got %b want 1", c, err_overflow); end
            settle(); clk_edge();
        end
        rst = 1; settle(); clk_edge();
        rst = 0;
        checks++;
        if (err_ack !== 1'b0 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL err_clear: err_ack=%b err_ovf=%b want 0 0", err_ack, err_overflow);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req             = N'($urandom);
            fifo_full       = ($urandom_range(0, 7) == 0);
            fifo_almostfull = ($urandom_range(0, 3) == 0);
            settle();
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt, exp_gnt); end
            clk_edge();
            checks++;
            if (fifo_wr_en !== m_wr_en || (m_wr_en && fifo_data_in !== m_data) ||
                err_ack !== m_eack || err_overflow !== m_eovf || busy !== ((|req) || m_wr_en)) begin
                errors++;
                $display("FAIL rand_out[%0d]: wr_en=%b data=%h eack=%b eovf=%b busy=%b want %b %h %b %b %b",
                         c, fifo_wr_en, fifo_data_in, err_ack, err_overflow, busy,
                         m_wr_en, m_data, m_eack, m_eovf, ((|req) || m_wr_en));
            end
            if (last_idx >= 0) pd[last_idx] = DW'($urandom);
        end
        req = '0; fifo_full = 0; fifo_almostfull = 0;
        settle(); clk_edge();
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        rst = 1; req = '0; settle(); clk_edge();
        rst = 0; req = 4'b0001;
        for (int c = 0; c < 5; c++) begin settle(); clk_edge(); end
        req = '0;
        checks++;
        if (grant_cnt[1:0] !== 2'd3 || grant_cnt[3:2] !== 2'd0 || int'(grant_cnt[1:0]) != m_cnt[0]) begin
            errors++; $display("FAIL stats_sat: cnt0=%0d cnt1=%0d want 3 0", grant_cnt[1:0], grant_cnt[3:2]);
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0; auto_ack = 1;
        rst = 1; req = '0;
        fifo_full = 0; fifo_almostfull = 0; fifo_wr_ack = 0; fifo_overflow = 0;
        for (int i = 0; i < N; i++) pd[i] = '0;
        m_ptr = 0; m_wr_en = 0; m_pend = 0; m_eack = 0; m_eovf = 0; m_data = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        exp_idx = -1; last_idx = -1; exp_gnt = '0;
        test_reset();
        test_mid_reset();
        test_round_robin();
        test_skip_wrap();
        test_full_boundary();
        test_errors();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
